// File: rtl/packet_receiver.sv
// Serial tile-word receiver: synchronizes an external SCLK/SDATA/SCS_N link,
// frames 16-bit words and hands valid ones to the maze mapper.
module packet_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SCLK,
  input  logic        SDATA,
  input  logic        SCS_N,
  output logic [15:0] DATA_OUT,
  output logic        DATA_VAL,
  output logic        FRAME_ERR,
  output logic [7:0]  ERR_COUNT
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          sclk_meta, sclk_sync, sclk_prev;
  logic          sdata_meta, sdata_sync;
  logic          scs_meta, scs_sync, scs_prev;
  logic [1:0]    sync_fill;
  logic          armed;
  logic [1:0]    state;
  logic [15:0]   shift_reg;
  logic [4:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;

  logic sclk_rise, scs_fall, scs_rise, frame_ok;

  // NOTE: every register here, including the synchronizers, uses non-blocking
  // assignments so each flop samples the pre-edge value of its neighbour.
  // SCS_N flops reset to the idle (high) level so reset release never looks
  // like a frame start by itself.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_meta  <= 1'b0;
      sclk_sync  <= 1'b0;
      sclk_prev  <= 1'b0;
      sdata_meta <= 1'b0;
      sdata_sync <= 1'b0;
      scs_meta   <= 1'b1;
      scs_sync   <= 1'b1;
      scs_prev   <= 1'b1;
    end else begin
      sclk_meta  <= SCLK;
      sclk_sync  <= sclk_meta;
      sclk_prev  <= sclk_sync;
      sdata_meta <= SDATA;
      sdata_sync <= sdata_meta;
      scs_meta   <= SCS_N;
      scs_sync   <= scs_meta;
      scs_prev   <= scs_sync;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign scs_fall  = ~scs_sync & scs_prev;
  assign scs_rise  = scs_sync & ~scs_prev;

  // A frame start only counts once SCS_N has been seen high with real pin
  // data (two cycles after reset), so a link already selected at reset is
  // ignored until it deselects and reselects.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && scs_sync) armed <= 1'b1;
    end
  end

  // y is two bits wide and therefore always within 0..3.
  assign frame_ok = (bit_cnt == 5'd16) && (shift_reg[15:13] <= 3'd4);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      DATA_OUT  <= '0;
      DATA_VAL  <= 1'b0;
      FRAME_ERR <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      DATA_VAL  <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (scs_fall && armed) begin
            state     <= SHIFT;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
          end
        end
        SHIFT: begin
          // Deselect wins over a coincident clock edge; that bit is dropped.
          if (scs_rise) begin
            state <= CHECK;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], sdata_sync};
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= ABORT;
            FRAME_ERR <= 1'b1;
            if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (frame_ok) begin
            DATA_OUT <= shift_reg;
            DATA_VAL <= 1'b1;
          end else begin
            FRAME_ERR <= 1'b1;
            if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
          end
        end
        default: begin
          // ABORT: already reported; wait out the rest of the frame silently.
          if (scs_sync) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/packet_receiver.md
PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the CLK cycles allowed between consecutive SCLK rising edges inside a frame before abort.
REQ-002 SHALL have port CLK  input  1  system clock (50 MHz); one clock domain only.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port SCLK  input  1  serial clock from the robot-side radio base station, asynchronous to CLK.
REQ-005 SHALL have port SDATA  input  1  serial data, MSB first, sampled on SCLK rising edge; asynchronous.
REQ-006 SHALL have port SCS_N  input  1  frame select, active-low; asynchronous.
REQ-007 SHALL have port DATA_OUT  output  16  last accepted tile word, in the maze mapper format: [15:13] x, [12:11] y, [7:0] tile bits.
REQ-008 SHALL have port DATA_VAL  output  1  one-CLK pulse marking a new DATA_OUT; drives the maze mapper write strobe.
REQ-009 SHALL have port FRAME_ERR  output  1  one-CLK pulse marking a rejected frame.
REQ-010 SHALL have port ERR_COUNT  output  8  count of rejected frames, saturating.

Function
REQ-011 SHALL pass each of SCLK, SDATA and SCS_N through its own 2-flop synchronizer; all logic uses only the synchronized copies.
REQ-012 SHALL detect SCLK rise and SCS_N fall/rise by comparing each synchronized signal with a registered copy of itself.
REQ-013 SHALL implement the FSM IDLE, SHIFT, CHECK, ABORT with these transitions: IDLE->SHIFT on SCS_N fall; SHIFT->CHECK on SCS_N rise; SHIFT->ABORT on timeout; CHECK->IDLE unconditionally after 1 cycle; ABORT->IDLE when synchronized SCS_N is high.
REQ-014 On entry to SHIFT, SHALL clear the shift register (16 bits) and the bit counter (5 bits).
REQ-015 In SHIFT, each SCLK rise SHALL shift SDATA into bit 0 and increment the bit counter, which saturates at 31.
REQ-016 SCLK edges outside SHIFT SHALL be ignored.
REQ-017 If SCLK rise and SCS_N rise are detected in the same cycle, the SCLK bit SHALL be discarded and SCS_N rise takes priority.
REQ-018 In CHECK, a frame SHALL be valid iff bit counter == 16, x (shift[15:13]) <= 4 and y (shift[12:11]) <= 3.
REQ-019 For a valid frame, DATA_OUT SHALL load the shift register and DATA_VAL SHALL be high for exactly the cycle after CHECK.
REQ-020 For an invalid frame, DATA_OUT SHALL be unchanged, FRAME_ERR SHALL be high for the cycle after CHECK, and ERR_COUNT SHALL increment.
REQ-021 Latency: DATA_VAL or FRAME_ERR SHALL be high after the 4th CLK rising edge, counting the first edge that samples SCS_N high.
REQ-022 Timeout counter: cleared on SHIFT entry and on every SCLK rise; increments each SHIFT cycle; reaching TIMEOUT_CYCLES enters ABORT with a one-cycle FRAME_ERR and an ERR_COUNT increment.
REQ-023 ERR_COUNT SHALL saturate at 255 and never wrap.
REQ-024 DATA_VAL and FRAME_ERR SHALL never be high in the same cycle, and SHALL be high for at most one cycle per frame.
REQ-025 A frame SHALL require an observed SCS_N fall; if SCS_N is already low at reset release, no frame is captured until SCS_N goes high and then low again.

Reset
REQ-026 While RST_N is low, all of the following SHALL hold, immediately and independent of CLK:
- FSM in IDLE.
- DATA_OUT = 16'h0000, DATA_VAL = 0, FRAME_ERR = 0, ERR_COUNT = 0.
- Shift register, bit counter and timeout counter all zero.
- SCS_N synchronizer flops at 1; SCLK and SDATA synchronizer flops at 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no DATA_VAL and no FRAME_ERR.

Verification
REQ-028 Send 16 bits 0x2A56 with SCLK period 40 CLK -> one DATA_VAL pulse, DATA_OUT = 0x2A56 (x=1, y=1, tile 0x56), ERR_COUNT = 0.
REQ-029 Send 0xA000 (x=5) -> FRAME_ERR pulse, DATA_OUT keeps its prior value 0x2A56, ERR_COUNT = 1.
REQ-030 Send 15 bits, then 17 bits -> two FRAME_ERR pulses, no DATA_VAL, ERR_COUNT += 2.
REQ-031 With TIMEOUT_CYCLES = 100, stop SCLK after 8 bits with SCS_N held low -> FRAME_ERR exactly 100 cycles after the last SCLK-rise detection; no further pulse on the later SCS_N rise; the next good frame is accepted.
REQ-032 Assert RST_N low after 10 bits, release, then send 0x0C81 -> no pulse from the aborted frame; DATA_VAL with DATA_OUT = 0x0C81.
REQ-033 Send 260 invalid frames -> ERR_COUNT holds 255 and does not wrap.
